// File: rtl/delay_timer_if.sv
// Handshake bundle between the decoder/program counter and the delay timer.
// Carries unit_sel only when DELAY_TIMER_UNIT_SEL_EN is defined.
interface delay_timer_if #(
  parameter int unsigned VAL_W = 16
);
  logic             delay;
  logic [VAL_W-1:0] delay_value;
  logic             pchalt;
`ifdef DELAY_TIMER_UNIT_SEL_EN
  logic             unit_sel;
`endif
  logic             count_done;
  logic             busy;
  logic [VAL_W-1:0] remaining;

  modport master (
`ifdef DELAY_TIMER_UNIT_SEL_EN
    output unit_sel,
`endif
    output delay, delay_value, pchalt,
    input  count_done, busy, remaining
  );

  modport slave (
`ifdef DELAY_TIMER_UNIT_SEL_EN
    input  unit_sel,
`endif
    input  delay, delay_value, pchalt,
    output count_done, busy, remaining
  );
endinterface

// File: rtl/delay_timer.sv
// Program-counter delay responder: counts delay_value units of PRESCALE clocks, then pulses count_done.
// Optional DELAY_TIMER_UNIT_SEL_EN adds unit_sel choosing US_PRESCALE clocks per unit.
module delay_timer #(
  parameter int unsigned VAL_W       = 16,
  parameter int unsigned PRESCALE    = 100000,
  parameter int unsigned PRE_W       = 17
`ifdef DELAY_TIMER_UNIT_SEL_EN
  , parameter int unsigned US_PRESCALE = 100
`endif
) (
  input logic         clk,
  input logic         rst,
  delay_timer_if.slave bus
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
`ifdef DELAY_TIMER_UNIT_SEL_EN
  localparam logic [PRE_W-1:0] US_LAST  = PRE_W'(US_PRESCALE - 1);
`endif

  typedef enum logic [1:0] {IDLE, COUNT, DONE, RECOVER} state_t;

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic [VAL_W-1:0] remaining;
  logic             count_done;
  logic             busy;
  logic [PRE_W-1:0] unit_last;

`ifdef DELAY_TIMER_UNIT_SEL_EN
  logic unit_q;
  assign unit_last = unit_q ? US_LAST : PRE_LAST;
`else
  assign unit_last = PRE_LAST;
`endif

  // Single registered FSM; outputs updated alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prescaler  <= '0;
      remaining  <= '0;
      count_done <= 1'b0;
      busy       <= 1'b0;
`ifdef DELAY_TIMER_UNIT_SEL_EN
      unit_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.delay && !bus.pchalt) begin
            remaining <= bus.delay_value;
            prescaler <= '0;
            busy      <= 1'b1;
`ifdef DELAY_TIMER_UNIT_SEL_EN
            unit_q    <= bus.unit_sel;
`endif
            if (bus.delay_value != '0) begin
              state <= COUNT;
            end else begin
              state      <= DONE;
              count_done <= 1'b1;
            end
          end
        end

        COUNT: begin
          if (bus.pchalt) begin
            state <= COUNT;
          end else if (!bus.delay) begin
            // Decoder moved on: abandon the delay silently
            state     <= IDLE;
            remaining <= '0;
            prescaler <= '0;
            busy      <= 1'b0;
          end else if (prescaler == unit_last) begin
            prescaler <= '0;
            if (remaining == VAL_W'(1)) begin
              state      <= DONE;
              remaining  <= '0;
              count_done <= 1'b1;
            end else begin
              remaining <= remaining - VAL_W'(1);
            end
          end else begin
            prescaler <= prescaler + PRE_W'(1);
          end
        end

        DONE: begin
          // Stretch the pulse while the program counter is frozen
          if (!bus.pchalt) begin
            state      <= RECOVER;
            count_done <= 1'b0;
            busy       <= 1'b0;
          end
        end

        RECOVER: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.count_done = count_done;
  assign bus.busy       = busy;
  assign bus.remaining  = remaining;

endmodule

// File: doc/delay_timer.md
Name: delay_timer

Overview:
- Responder side of the program-counter delay handshake.
- When the decoded instruction requests a delay, the block counts `delay_value` time units of `PRESCALE` clocks each. It then pulses `count_done` so the program counter advances past the delay instruction.
- Sits between the instruction decoder (source of `delay` and `delay_value`) and the program counter (sink of `count_done`). Shares `pchalt` with the program counter.

Parameters:
- VAL_W, 16, width of `delay_value` and `remaining`.
- PRESCALE, 100000, clocks per time unit (1 ms at 100 MHz); legal range 2..2^PRE_W.
- PRE_W, 17, prescaler counter width; must satisfy 2^PRE_W >= PRESCALE.
- US_PRESCALE, 100, clocks per unit when µs mode is selected (only used with DELAY_TIMER_UNIT_SEL_EN).

Ports:
- clk  in  1  system clock, 100 MHz, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- delay  in  1  decoder: current instruction is a delay instruction
- delay_value  in  VAL_W  decoder: delay length in time units, sampled only on IDLE->COUNT
- pchalt  in  1  global halt, shared with the program counter
- count_done  out  1  delay complete; program counter increments when delay=1 and count_done=1
- busy  out  1  high in COUNT and DONE
- remaining  out  VAL_W  units left, including the unit in progress (debug/status)

Behaviour:
- States: IDLE, COUNT, DONE, RECOVER.
- All outputs are registered. `count_done` = (state==DONE); `busy` = COUNT|DONE.
- Reset: synchronous, applied on rising edge with rst=1, valid at any time including mid-count.
  - state=IDLE, prescaler=0, remaining=0, count_done=0, busy=0.
  - An in-flight delay is discarded with no pulse.
- IDLE:
  - If delay=1 and pchalt=0: latch delay_value into remaining, prescaler=0.
  - Go to COUNT if delay_value!=0, else go to DONE directly (zero-length delay, 1-cycle latency).
  - Otherwise stay in IDLE.
- COUNT:
  - If pchalt=1: freeze prescaler and remaining; stay in COUNT.
  - Else if delay=0 (abort): go to IDLE, remaining=0, no pulse.
  - Else prescaler++. When prescaler==PRESCALE-1: prescaler=0; if remaining==1 go to DONE with remaining=0, else remaining--.
- Latency: with delay sampled in IDLE at edge k (N>0, no halt), DONE is entered at edge k+N*PRESCALE. count_done is high for the following cycle.
- DONE:
  - count_done=1.
  - If pchalt=1: hold DONE, so the pulse stretches and is not lost while the program counter is frozen.
  - Else go to RECOVER. The program counter increments on this same edge.
- RECOVER:
  - One cycle, count_done=0.
  - Absorbs instruction-memory read latency so the stale delay of the previous instruction is not re-accepted. Always go to IDLE.
- Back-to-back delay instructions:
  - The second is accepted in IDLE two cycles after the DONE exit.
  - The program counter holds meanwhile, because delay=1 and count_done=0.
- delay_value changes during COUNT are ignored.
- pchalt in IDLE blocks the start; pchalt in RECOVER has no effect.
- Arithmetic: unsigned, no wrap. The prescaler never exceeds PRESCALE-1, and remaining never underflows below 0.

Optional Feature:
- Macro: DELAY_TIMER_UNIT_SEL_EN.
- With the macro defined:
  - Adds input unit_sel (1 bit), sampled on IDLE->COUNT together with delay_value.
  - 0 selects PRESCALE clocks/unit (ms); 1 selects US_PRESCALE clocks/unit (µs).
  - The selection is held in a register for the whole delay.
- Without the macro: no unit_sel port; the unit is always PRESCALE clocks.

Test Plan (PRESCALE=4 overridden):
- Reset then delay=1, delay_value=3 at edge k -> count_done=1 exactly during cycle after edge k+12, busy=1 from k+1, then IDLE via RECOVER.
- delay=1, delay_value=0 -> count_done high the cycle after acceptance, remaining=0, no COUNT cycles.
- delay_value=2, pchalt=1 for 5 cycles mid-COUNT -> remaining/prescaler frozen; pulse delayed by exactly 5 cycles. pchalt=1 during DONE for 3 cycles -> count_done high 4 cycles.
- delay dropped to 0 after 5 cycles of COUNT -> IDLE, count_done never asserts, remaining=0.
- rst=1 mid-COUNT with remaining=2 -> next cycle all outputs 0, state IDLE. delay held 1 afterward -> fresh full-length delay.
- Back-to-back delays (3 then 1 unit, delay held 1) -> two single-cycle pulses, 12+1+... second pulse 2+4 cycles after first. With DELAY_TIMER_UNIT_SEL_EN, US_PRESCALE=2, unit_sel=1, value=3 -> pulse after 6 cycles.
